// File: rtl/regseq_pkg.sv
// regseq_pkg: shared types and constants for the register-file sequencer.
//   op_e     : ALU command opcodes (3 bits)
//   state_e  : sequencer FSM states
//   NUM_REGS : implemented register count (indices 0..NUM_REGS-1)
//   PARK_ADDR: write index driven whenever no write is intended (>= NUM_REGS)
//   op_writes / op_uses_rs / op_uses_rt: per-opcode operand usage
package regseq_pkg;

    localparam int NUM_REGS  = 16;
    localparam int PARK_ADDR = 31;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        AND  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        ADDI = 3'd5,
        LI   = 3'd6,
        RD   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Every op except RD produces a register write-back.
    function automatic logic op_writes(op_e op);
        return op != RD;
    endfunction

    // LI takes its value from the immediate only.
    function automatic logic op_uses_rs(op_e op);
        return op != LI;
    endfunction

    function automatic logic op_uses_rt(op_e op);
        return op inside {ADD, SUB, AND, OR, XOR};
    endfunction

endpackage

// File: rtl/regseq_alu.sv
// regseq_alu: combinational result generator for the sequencer.
// Ports:
//   op     : opcode (regseq_pkg::op_e)
//   a, b   : source register values (rs, rt)
//   imm    : 16-bit immediate
//   result : op result, modulo 2^DATA_W, no flags
module regseq_alu
    import regseq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [15:0]       imm,
    output logic [DATA_W-1:0] result
);

    logic signed [DATA_W-1:0] aS;
    logic signed [DATA_W-1:0] bS;
    logic signed [DATA_W-1:0] immSext;
    logic        [DATA_W-1:0] immZext;

    assign aS      = a;
    assign bS      = b;
    assign immSext = {{(DATA_W-16){imm[15]}}, imm};
    assign immZext = {{(DATA_W-16){1'b0}}, imm};

    always_comb begin
        result = '0;
        case (op)
            ADD:     result = aS + bS;
            SUB:     result = aS - bS;
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            ADDI:    result = aS + immSext;
            LI:      result = immZext;
            RD:      result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: accepts one ALU-style command per handshake, reads the
// source registers from an external 16-entry register file, computes the
// result, writes it back and returns a response.
// Ports:
//   clk, rst              : clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake; cmd_op/rd/rs/rt/imm fields
//   rf_rd_addr_a/b        : register file read addresses (data returns next cycle)
//   rf_rd_data_a/b        : register file read data
//   rf_wr_addr/rf_wr_data : register file write port (writes every edge;
//                           parked at PARK_ADDR when no write is intended)
//   rsp_valid/rsp_ready   : response handshake; rsp_data, rsp_err
// Optional build macro REGSEQ_CMD_COUNT_EN adds cmd_count[15:0], a wrapping
// count of completed response handshakes.
module regfile_sequencer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_REGS  = regseq_pkg::NUM_REGS,
    parameter int PARK_ADDR = regseq_pkg::PARK_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [15:0]       cmd_imm,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    input  logic [DATA_W-1:0] rf_rd_data_a,
    input  logic [DATA_W-1:0] rf_rd_data_b,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
`ifdef REGSEQ_CMD_COUNT_EN
    ,
    output logic [15:0]       cmd_count
`endif
);

    import regseq_pkg::*;

    localparam logic [ADDR_W:0]   NUM_REGS_CMP = NUM_REGS[ADDR_W:0];
    localparam logic [ADDR_W-1:0] PARK_IDX     = PARK_ADDR[ADDR_W-1:0];

    function automatic logic outOfRange(logic [ADDR_W-1:0] idx);
        return {1'b0, idx} >= NUM_REGS_CMP;
    endfunction

    state_e            state;
    state_e            stateNext;
    logic              accept;
    op_e               opReg;
    logic [ADDR_W-1:0] rdReg;
    logic [15:0]       immReg;
    logic [DATA_W-1:0] aluResult;
    logic              errNow;

    regseq_alu #(
        .DATA_W (DATA_W)
    ) uAlu (
        .op     (opReg),
        .a      (rf_rd_data_a),
        .b      (rf_rd_data_b),
        .imm    (immReg),
        .result (aluResult)
    );

    // Source indices live in rf_rd_addr_a/b for the whole command, so the
    // index check can use them directly; unused fields are masked per op.
    assign errNow = (op_writes(opReg)  && outOfRange(rdReg))        ||
                    (op_uses_rs(opReg) && outOfRange(rf_rd_addr_a)) ||
                    (op_uses_rt(opReg) && outOfRange(rf_rd_addr_b));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept    = 1'b1;
                    stateNext = READ;
                end
            end
            READ:  stateNext = EXEC;
            EXEC:  stateNext = WRITE;
            WRITE: stateNext = RESP;
            RESP:  if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Command fields are plain data: captured on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            opReg  <= op_e'(cmd_op);
            rdReg  <= cmd_rd;
            immReg <= cmd_imm;
        end
    end

    // Registered outputs. The async reset parks the write address, which is
    // what drops a write caught mid-flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_data     <= '0;
            rf_wr_addr   <= PARK_IDX;
            rf_wr_data   <= '0;
            rf_rd_addr_a <= '0;
            rf_rd_addr_b <= '0;
        end else begin
            cmd_ready <= (stateNext == IDLE);
            if (accept) begin
                rf_rd_addr_a <= cmd_rs;
                rf_rd_addr_b <= cmd_rt;
            end
            case (state)
                EXEC: begin
                    rsp_data <= errNow ? '0 : aluResult;
                    rsp_err  <= errNow;
                    if (op_writes(opReg) && !errNow) begin
                        rf_wr_addr <= rdReg;
                        rf_wr_data <= aluResult;
                    end
                end
                WRITE: begin
                    rf_wr_addr <= PARK_IDX;
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef REGSEQ_CMD_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        cmd_count <= '0;
        else if (rsp_valid && rsp_ready) cmd_count <= cmd_count + 16'd1;
    end
`endif

endmodule
